// File: rtl/c432_seq_pkg.sv
// Shared types and field layout for the c432 vector sequencer.
package c432_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int VEC_W   = 36;
    localparam int RSP_W   = 7;
    localparam int ENTRY_W = VEC_W + RSP_W;
    localparam int FLD_W   = 9;

    // Stimulus fields inside the 36-bit vector {E,A,B,C}
    localparam int E_LSB = 27;
    localparam int A_LSB = 18;
    localparam int B_LSB = 9;
    localparam int C_LSB = 0;

    // Response fields inside the 7-bit expected value {PA,PB,PC,Chan}
    localparam int PA_BIT   = 6;
    localparam int PB_BIT   = 5;
    localparam int PC_BIT   = 4;
    localparam int CHAN_LSB = 0;
    localparam int CHAN_W   = 4;

    // A store entry is {vec, exp}; the vector sits above the response
    localparam int VEC_LSB = RSP_W;

endpackage

// File: rtl/c432_vec_store.sv
// Vector/expected-response register file: reset to zero, synchronous write,
// asynchronous read.
module c432_vec_store
    import c432_seq_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [DEPTH-1:0][ENTRY_W-1:0] mem;

    // Entry array; one write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/c432_vector_sequencer.sv
// Drives the c432 core with a stored list of {E,A,B,C} vectors, holds each
// for a programmable settle time, samples the core response and counts
// mismatches. Also owns the core clock-mux select.
module c432_vector_sequencer
    import c432_seq_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int SETTLE_W = 4,
    parameter  int ERR_W    = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [VEC_W-1:0]    cfg_vec,
    input  logic [RSP_W-1:0]    cfg_exp,
    input  logic [AW:0]         num_vec,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                loop_en,
    input  logic                fast_mode,
    input  logic                start,
    input  logic                stop,
    output logic [FLD_W-1:0]    E_out,
    output logic [FLD_W-1:0]    A_out,
    output logic [FLD_W-1:0]    B_out,
    output logic [FLD_W-1:0]    C_out,
    input  logic                PA_in,
    input  logic                PB_in,
    input  logic                PC_in,
    input  logic [CHAN_W-1:0]   Chan_in,
    output logic                select_out,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_cnt,
    output logic                err_valid,
    output logic [AW-1:0]       first_err_idx
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    state_t              state, state_nxt;
    logic [AW-1:0]       idx_q, rd_addr;
    logic [AW:0]         nv_q, nv_clamp;
    logic [SETTLE_W-1:0] settle_q, cnt_q;
    logic                loop_q, last, start_ok, mism;
    logic [RSP_W-1:0]    exp_q, rsp;
    logic [ENTRY_W-1:0]  rd_entry;
    logic [VEC_W-1:0]    rd_vec;

    assign nv_clamp = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
    assign last     = ({1'b0, idx_q} == nv_q - (AW+1)'(1));
    assign start_ok = start && (state == IDLE || state == DONE);
    assign rsp      = {PA_in, PB_in, PC_in, Chan_in};
    assign mism     = (rsp != exp_q);
    assign rd_vec   = rd_entry[VEC_LSB +: VEC_W];

    // Writes are locked out while a run is using the store
    c432_vec_store #(.DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata ({cfg_vec, cfg_exp}),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; the read address is the index of the vector about to be
    // loaded, so stimulus and its expected value enter APPLY together
    always_comb begin
        state_nxt = state;
        rd_addr   = idx_q;
        case (state)
            IDLE, DONE: begin
                rd_addr = '0;
                if (start) state_nxt = (nv_clamp == '0) ? DONE : APPLY;
            end
            APPLY:   state_nxt = stop ? DONE : SETTLE;
            SETTLE: begin
                if (stop)              state_nxt = DONE;
                else if (cnt_q == '0)  state_nxt = CAPTURE;
            end
            CAPTURE: begin
                rd_addr = last ? '0 : idx_q + AW'(1);
                if (stop || (last && !loop_q)) state_nxt = DONE;
                else                           state_nxt = APPLY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run configuration, stimulus, settle counter, error bookkeeping, flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nv_q          <= '0;
            settle_q      <= '0;
            loop_q        <= 1'b0;
            select_out    <= 1'b1;
            idx_q         <= '0;
            exp_q         <= '0;
            cnt_q         <= '0;
            E_out         <= '0;
            A_out         <= '0;
            B_out         <= '0;
            C_out         <= '0;
            err_cnt       <= '0;
            err_valid     <= 1'b0;
            first_err_idx <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (start_ok) begin
                nv_q          <= nv_clamp;
                settle_q      <= settle;
                loop_q        <= loop_en;
                select_out    <= ~fast_mode;
                err_cnt       <= '0;
                err_valid     <= 1'b0;
                first_err_idx <= '0;
            end
            if (state_nxt == APPLY) begin
                idx_q <= rd_addr;
                exp_q <= rd_entry[RSP_W-1:0];
                E_out <= rd_vec[E_LSB +: FLD_W];
                A_out <= rd_vec[A_LSB +: FLD_W];
                B_out <= rd_vec[B_LSB +: FLD_W];
                C_out <= rd_vec[C_LSB +: FLD_W];
            end
            if (state == APPLY)       cnt_q <= settle_q;
            else if (state == SETTLE) cnt_q <= cnt_q - SETTLE_W'(1);
            if (state == CAPTURE && mism) begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (!err_valid) begin
                    err_valid     <= 1'b1;
                    first_err_idx <= idx_q;
                end
            end
            busy <= (state_nxt == APPLY) || (state_nxt == SETTLE) || (state_nxt == CAPTURE);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: doc/c432_vector_sequencer.md
Name: c432_vector_sequencer

Overview:
Sequencer/checker that drives the c432 interrupt-priority core (TopLevel432) with a programmable list of {E,A,B,C} vectors and holds each vector for a configurable settle time. It samples PA/PB/PC/Chan, compares them against stored expected responses, and counts mismatches. It also drives the core-clock-mux select (nominal vs. overclocked) for timing-error experiments. It runs on its own clk, not on the muxed core clock.

Parameters:
DEPTH, 8, number of vector entries (power of 2, 2..16)
SETTLE_W, 4, width of settle-cycle count
ERR_W, 8, width of mismatch counter

Ports:
clk  in  1  sequencer clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write strobe for the vector store
cfg_addr  in  log2(DEPTH)  entry index
cfg_vec  in  36  stimulus {E[8:0],A[8:0],B[8:0],C[8:0]}
cfg_exp  in  7  expected {PA,PB,PC,Chan[3:0]}
num_vec  in  log2(DEPTH)+1  vectors per pass (0..DEPTH)
settle  in  SETTLE_W  extra hold cycles per vector
loop_en  in  1  repeat pass until stop
fast_mode  in  1  1 = request the overclocked core clock
start  in  1  single-cycle run request
stop  in  1  abort request
E_out, A_out, B_out, C_out  out  9 each  stimulus to core (registered)
PA_in, PB_in, PC_in  in  1 each  core responses
Chan_in  in  4  core channel response
select_out  out  1  clock-mux select: 1 = nominal clk1, 0 = fast clk2
busy  out  1  run in progress
done  out  1  sticky run-complete flag
err_cnt  out  ERR_W  saturating mismatch count
err_valid  out  1  at least one mismatch this run
first_err_idx  out  log2(DEPTH)  entry index of the first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; stimulus outputs 0; select_out=1; busy=0; done=0; err_cnt=0; err_valid=0; first_err_idx=0; all vector-store entries 0.
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- Vector store: synchronous write when cfg_we=1 and busy=0; asynchronous read. A cfg_we while busy=1 is dropped silently.
- IDLE/DONE with start=1:
  - latch num_vec, settle, loop_en, fast_mode; select_out <= ~fast_mode; clear done, err_cnt, err_valid, first_err_idx; idx <= 0.
  - num_vec=0 -> go directly to DONE (done=1, busy=0).
  - num_vec>DEPTH -> clamp to DEPTH.
  - otherwise go to APPLY.
- Mid-run changes: start while busy is ignored. select_out changes only on an accepted start.
- APPLY (1 cycle): stimulus registers load entry[idx] on entry to APPLY. Wait counter loads settle; next state is SETTLE.
- SETTLE: counter decrements each cycle; at counter==0 go to CAPTURE. SETTLE therefore lasts settle+1 cycles.
- CAPTURE (1 cycle): on the edge leaving CAPTURE, compare {PA_in,PB_in,PC_in,Chan_in} with exp[idx].
  - Mismatch: err_cnt+1, saturating at all-ones.
  - First mismatch of the run: err_valid=1, first_err_idx=idx.
- Per-vector period is settle+3 cycles; stimulus is stable for settle+2 edges before the sample edge.
- Leaving CAPTURE:
  - idx<num_vec-1 -> idx+1, go to APPLY.
  - idx==num_vec-1 and loop_en=1 -> idx=0, go to APPLY.
  - idx==num_vec-1 and loop_en=0 -> go to DONE.
- stop=1 in APPLY or SETTLE: go to DONE next edge, no compare.
- stop=1 in CAPTURE: the compare still happens, then go to DONE.
- DONE: busy=0, done=1, stimulus outputs hold their last vector.
- busy=1 exactly in APPLY, SETTLE and CAPTURE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package c432_seq_pkg holds:
  - state enum (IDLE, APPLY, SETTLE, CAPTURE, DONE);
  - VEC_W=36, RSP_W=7, ENTRY_W=43;
  - field-slice constants for E/A/B/C/PA/PB/PC/Chan.
- Sub-module c432_vec_store: DEPTH x ENTRY_W register file, reset to 0, synchronous write, asynchronous read.

Test Plan:
- Reset mid-run: assert rst_n=0 during SETTLE -> all outputs at reset values immediately; state IDLE; select_out=1.
- Single pass, all matching:
  - Program entry0 = {E=1FF,A=002,B=001,C=000}, exp 7'h12; entry1 = {000,002,001,000}, exp 7'h05.
  - Core stub returns the matching values; num_vec=2, settle=2, start.
  - Required: E_out=1FF one edge after start; sample 4 cycles later; done after 10 cycles; err_cnt=0; err_valid=0.
- Mismatch capture:
  - Same setup, but the stub returns 7'h00 for entry1.
  - Required: err_cnt=1, err_valid=1, first_err_idx=1.
  - Then run num_vec=DEPTH with every entry mismatching and loop_en=1 for 300 vectors -> err_cnt saturates at 8'hFF.
- Loop and stop:
  - loop_en=1, num_vec=3: idx wraps 2->0.
  - stop asserted in CAPTURE of idx1 -> idx1 is compared, done=1, E_out holds entry1's E.
- Boundaries:
  - num_vec=0 -> done the cycle after start, busy never 1.
  - num_vec=15 with DEPTH=8 -> 8 vectors applied.
  - settle=0 -> per-vector period 3 cycles.
- Config guards:
  - cfg_we during busy -> entry unchanged afterwards.
  - fast_mode=1 with start -> select_out=0.
  - fast_mode toggled while busy -> select_out unchanged.
